// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered frame data, 16-level
// PWM brightness, anti-ghost dead time, per-digit blink and global blank.
module seg_scan_ctrl #(
  parameter int NDIG        = 8,
  parameter int SCAN_W      = 15,
  parameter int DEAD        = 16,
  parameter int BLINK_W     = 5,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NDIG*8-1:0] data_i,
  input  logic              load_i,
  input  logic [NDIG-1:0]   blink_i,
  input  logic [3:0]        bright_i,
  input  logic              en_i,
  output logic [NDIG-1:0]   an_o,
  output logic [7:0]        seg_o,
  output logic              frame_o,
  output logic              pend_o
);

  localparam int                DW       = $clog2(NDIG);
  localparam logic [SCAN_W-1:0] DEAD_C   = SCAN_W'(DEAD);
  localparam logic [DW-1:0]     LAST_DIG = DW'(NDIG - 1);
  localparam logic [NDIG-1:0]   AN_OFF   = AN_ACT_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};
  localparam logic [7:0]        SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [SCAN_W-1:0]  slot_cnt;
  logic [DW-1:0]      dig;
  logic [NDIG*8-1:0]  act_buf;
  logic [NDIG*8-1:0]  stg_buf;
  logic               pend;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;
  logic               frame_p1;
  logic [NDIG-1:0]    an_p1;
  logic [7:0]         seg_p1;

  logic               slot_end;
  logic               frame_end;
  logic               lit;
  logic [7:0]         cur_byte;
  logic [NDIG-1:0]    an_d;
  logic [7:0]         seg_d;

  assign slot_end  = (slot_cnt == {SCAN_W{1'b1}});
  assign frame_end = slot_end && (dig == LAST_DIG);

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < NDIG; k++) begin
      if (dig == DW'(k)) cur_byte = act_buf[k*8 +: 8];
    end
  end

  // PWM window: top 4 bits of the slot counter against the brightness level
  always_comb begin
    lit = en_i
        && (slot_cnt >= DEAD_C)
        && (slot_cnt[SCAN_W-1 -: 4] <= bright_i)
        && !(blink_i[dig] && blink_ph);
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      an_d  = ({{(NDIG-1){1'b0}}, 1'b1} << dig) ^ AN_OFF;
      seg_d = cur_byte ^ SEG_OFF;
    end
  end

  // scan state and frame buffers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_cnt  <= '0;
      dig       <= '0;
      act_buf   <= '0;
      stg_buf   <= '0;
      pend      <= 1'b0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + SCAN_W'(1);
      if (slot_end) dig <= (dig == LAST_DIG) ? '0 : dig + DW'(1);
      if (frame_end) begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
        if (blink_cnt == {BLINK_W{1'b1}}) blink_ph <= ~blink_ph;
        if (load_i)    act_buf <= data_i;
        else if (pend) act_buf <= stg_buf;
        pend <= 1'b0;
      end else if (load_i) begin
        stg_buf <= data_i;
        pend    <= 1'b1;
      end
    end
  end

  // output register stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_p1 <= 1'b0;
      an_p1    <= AN_OFF;
      seg_p1   <= SEG_OFF;
    end else begin
      frame_p1 <= frame_end;
      an_p1    <= an_d;
      seg_p1   <= seg_d;
    end
  end

  assign an_o    = an_p1;
  assign seg_o   = seg_p1;
  assign frame_o = frame_p1;
  assign pend_o  = pend;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: timeline model checked every cycle plus directed literals.
module tb_seg_scan_ctrl;

  localparam int NDIG    = 4;
  localparam int SCAN_W  = 6;
  localparam int DEAD    = 2;
  localparam int BLINK_W = 1;
  localparam int SLOT    = 1 << SCAN_W;
  localparam int FRAME   = SLOT * NDIG;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NDIG*8-1:0] data_i;
  logic              load_i;
  logic [NDIG-1:0]   blink_i;
  logic [3:0]        bright_i;
  logic              en_i;
  logic [NDIG-1:0]   an_o;
  logic [7:0]        seg_o;
  logic              frame_o;
  logic              pend_o;

  int n_cmp = 0;
  int n_err = 0;
  int e = 0;

  logic [NDIG*8-1:0] m_act = '0;
  logic [NDIG*8-1:0] m_stg = '0;
  logic              m_pend = 1'b0;
  logic [NDIG-1:0]   exp_an = 4'hF;
  logic [7:0]        exp_seg = 8'hFF;
  logic              exp_frame = 1'b0;

  seg_scan_ctrl #(
    .NDIG(NDIG), .SCAN_W(SCAN_W), .DEAD(DEAD), .BLINK_W(BLINK_W),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .load_i(load_i),
    .blink_i(blink_i), .bright_i(bright_i), .en_i(en_i),
    .an_o(an_o), .seg_o(seg_o), .frame_o(frame_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (edge %0d, time %0t)", nm, act, exp, e, $time);
    end
  endtask

  // Model: e is the number of cycles since reset release, so position in the
  // scan is plain div/mod arithmetic on it.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e         <= 0;
      m_act     <= '0;
      m_stg     <= '0;
      m_pend    <= 1'b0;
      exp_an    <= 4'hF;
      exp_seg   <= 8'hFF;
      exp_frame <= 1'b0;
    end else begin : mdl
      int slot, dg, fr;
      bit ph, lit, bnd;
      slot = e % SLOT;
      dg   = (e / SLOT) % NDIG;
      fr   = e / FRAME;
      ph   = ((fr >> BLINK_W) & 1) == 1;
      lit  = en_i && (slot >= DEAD) && ((slot / (SLOT / 16)) <= int'(bright_i))
             && !(blink_i[dg] && ph);
      bnd  = (e % FRAME) == FRAME - 1;
      exp_an    <= lit ? ~(4'b0001 << dg) : 4'hF;
      exp_seg   <= lit ? ~m_act[dg*8 +: 8] : 8'hFF;
      exp_frame <= bnd;
      if (bnd) begin
        if (load_i)      m_act <= data_i;
        else if (m_pend) m_act <= m_stg;
        m_pend <= 1'b0;
      end else if (load_i) begin
        m_stg  <= data_i;
        m_pend <= 1'b1;
      end
      e <= e + 1;
    end
  end

  always @(negedge clk) begin
    chk("an_model", an_o, exp_an);
    chk("seg_model", seg_o, exp_seg);
    chk("frame_model", frame_o, exp_frame);
    chk("pend_model", pend_o, m_pend);
  end

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (e < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (e != target) begin
      n_err++;
      $display("FAIL goto_timeout: reached edge %0d, want %0d", e, target);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", e);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; data_i = '0; load_i = 1'b0; blink_i = '0; bright_i = 4'd15; en_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", an_o, 4'hF);
    chk("rst_seg", seg_o, 8'hFF);
    chk("rst_frame", frame_o, 1'b0);
    chk("rst_pend", pend_o, 1'b0);
    rstn = 1'b1;

    // scan order and dead time
    goto(2);   chk("an_dead", an_o, 4'hF);
    goto(3);   chk("an_d0_first", an_o, 4'b1110);
    goto(10);  data_i = 32'h3F06_5B4F; load_i = 1'b1;
    goto(11);  load_i = 1'b0; chk("pend_set", pend_o, 1'b1);
    goto(64);  chk("an_d0_last", an_o, 4'b1110); chk("seg_blank_old", seg_o, 8'hFF);
    goto(65);  chk("an_gap0", an_o, 4'hF);
    goto(66);  chk("an_gap1", an_o, 4'hF);
    goto(67);  chk("an_d1_first", an_o, 4'b1101);
    goto(255); chk("pend_hold", pend_o, 1'b1); chk("frame_low", frame_o, 1'b0);
    goto(256); chk("frame_pulse", frame_o, 1'b1); chk("pend_clear", pend_o, 1'b0);
    goto(257); chk("frame_one_cycle", frame_o, 1'b0);
    goto(260); chk("seg_d0_new", seg_o, 8'hB0); chk("an_d0_new", an_o, 4'b1110);
    goto(459); chk("seg_d3_new", seg_o, 8'hC0); chk("an_d3_new", an_o, 4'b0111);

    // load on the boundary beats staged data
    goto(600); data_i = 32'h1122_3344; load_i = 1'b1;
    goto(601); load_i = 1'b0;
    goto(767); data_i = 32'h667D_077F; load_i = 1'b1;
    goto(768); load_i = 1'b0; chk("pend_bnd", pend_o, 1'b0); chk("frame_bnd", frame_o, 1'b1);
    goto(774); chk("seg_bnd_B", seg_o, 8'h80);

    // brightness
    goto(1024); bright_i = 4'd3;
    goto(1040); chk("an_b3_last", an_o, 4'b1110);
    goto(1041); chk("an_b3_off", an_o, 4'hF);
    goto(1280); bright_i = 4'd0;
    goto(1282); chk("an_b0_dead", an_o, 4'hF);
    goto(1284); chk("an_b0_last", an_o, 4'b1110);
    goto(1285); chk("an_b0_off", an_o, 4'hF);

    // blink and blank
    goto(1536); bright_i = 4'd15; blink_i = 4'b0010;
    goto(1542); chk("an_blink_other", an_o, 4'b1110);
    goto(1606); chk("an_blink_dark", an_o, 4'hF);
    goto(2118); chk("an_blink_lit", an_o, 4'b1101);
    goto(2200); en_i = 1'b0;
    goto(2201); chk("an_en_off", an_o, 4'hF); chk("seg_en_off", seg_o, 8'hFF);
    goto(2210); en_i = 1'b1; blink_i = '0;

    // reset in the middle of digit 2 with data pending
    goto(2440); data_i = 32'hAABB_CCDD; load_i = 1'b1;
    goto(2441); load_i = 1'b0; chk("pend_before_rst", pend_o, 1'b1);
    goto(2460);
    rstn = 1'b0;
    #1;
    chk("midrst_an", an_o, 4'hF);
    chk("midrst_pend", pend_o, 1'b0);
    chk("midrst_seg", seg_o, 8'hFF);
    chk("midrst_frame", frame_o, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    goto(3);   chk("post_rst_an", an_o, 4'b1110); chk("post_rst_seg", seg_o, 8'hFF);
    goto(300); chk("post_rst_pend", pend_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
